// File: rtl/dspl_pkg.sv
// Shared types and constants for the 7-segment display scan receiver.
// Segment constants are active-high a..g, MSB = segment a.
package dspl_pkg;

    localparam int DIGIT_W  = 6;
    localparam int N_DIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    function automatic logic onehot_low(input logic [N_DIGITS-1:0] a);
        return $onehot(~a);
    endfunction

    function automatic logic [2:0] low_index(input logic [N_DIGITS-1:0] a);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (!a[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/dspl_scan_rx_seg7_dec.sv
// Active-high 7-segment pattern to hex digit; valid=0 for any
// pattern outside the sixteen glyphs.
module seg7_dec
    import dspl_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b1;
        hex   = 4'h0;
        unique case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/dspl_scan_rx.sv
// Rebuilds eight digit words from a scanned, possibly asynchronous,
// active-low anode/cathode display bus.
module dspl_scan_rx
    import dspl_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         an,
    input  logic [7:0]         dec_cat,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d2,
    output logic [DIGIT_W-1:0] d3,
    output logic [DIGIT_W-1:0] d4,
    output logic [DIGIT_W-1:0] d5,
    output logic [DIGIT_W-1:0] d6,
    output logic [DIGIT_W-1:0] d7,
    output logic [DIGIT_W-1:0] d8,
    output logic               frame_valid,
    output logic               seg_err,
    output logic [7:0]         frame_cnt
);

    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(FRAME_TIMEOUT);

    logic [7:0] an_sync  [SYNC_STAGES];
    logic [7:0] cat_sync [SYNC_STAGES];
    logic [7:0] an_s, cat_s, an_r, cat_r;

    state_t              state;
    logic [SW-1:0]       stab_cnt;
    logic [TW-1:0]       to_cnt;
    logic [DIGIT_W-1:0]  shadow [N_DIGITS];
    logic [DIGIT_W-1:0]  dq     [N_DIGITS];
    logic [N_DIGITS-1:0] seen;
    logic                err_acc;

    logic       an_oh, changed, capture, timeout, close;
    logic       dec_ok;
    logic [2:0] pos;
    logic [3:0] dec_hex;
    logic [6:0] seg_on;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                an_sync[i]  <= '1;
                cat_sync[i] <= '1;
            end
        end else begin
            an_sync[0]  <= an;
            cat_sync[0] <= dec_cat;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                an_sync[i]  <= an_sync[i-1];
                cat_sync[i] <= cat_sync[i-1];
            end
        end
    end

    assign an_s   = an_sync[SYNC_STAGES-1];
    assign cat_s  = cat_sync[SYNC_STAGES-1];
    assign seg_on = ~cat_s[7:1];

    seg7_dec u_dec (
        .seg   (seg_on),
        .valid (dec_ok),
        .hex   (dec_hex)
    );

    assign an_oh   = onehot_low(an_s);
    assign pos     = low_index(an_s);
    assign changed = (an_s != an_r) || (cat_s != cat_r);
    // The sample that completes the stable run is itself counted.
    assign capture = (state == SETTLE) && !changed
                     && (stab_cnt == SW'(STABLE_CYCLES - 2));
    assign timeout = (seen != '0) && (to_cnt == TW'(FRAME_TIMEOUT - 1));
    assign close   = (capture && pos == 3'd0 && seen != '0) || timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stab_cnt    <= '0;
            an_r        <= '1;
            cat_r       <= '1;
            to_cnt      <= '0;
            seen        <= '0;
            err_acc     <= 1'b0;
            shadow      <= '{default: '0};
            dq          <= '{default: '0};
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= close;
            if (close) begin
                for (int i = 0; i < N_DIGITS; i++)
                    dq[i] <= seen[i] ? shadow[i] : '0;
                seg_err   <= err_acc;
                frame_cnt <= frame_cnt + 8'd1;
            end

            // A capture coinciding with a close opens the next frame.
            seen    <= (close ? '0 : seen)
                       | (capture ? (N_DIGITS'(1) << pos) : '0);
            err_acc <= (close ? 1'b0 : err_acc)
                       | (capture && !dec_ok)
                       | (state == IDLE && !an_oh && an_s != '1);
            if (capture)
                shadow[pos] <= {1'b1, (dec_ok ? dec_hex : 4'h0), ~cat_s[0]};

            if (capture || close)
                to_cnt <= '0;
            else if (seen != '0)
                to_cnt <= to_cnt + TW'(1);

            unique case (state)
                IDLE: begin
                    if (an_oh) begin
                        state    <= SETTLE;
                        stab_cnt <= '0;
                        an_r     <= an_s;
                        cat_r    <= cat_s;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        stab_cnt <= '0;
                        an_r     <= an_s;
                        cat_r    <= cat_s;
                        if (!an_oh) state <= IDLE;
                    end else if (capture) begin
                        state <= HOLD;
                    end else begin
                        stab_cnt <= stab_cnt + SW'(1);
                    end
                end
                HOLD: begin
                    if (an_s != an_r) begin
                        stab_cnt <= '0;
                        an_r     <= an_s;
                        cat_r    <= cat_s;
                        state    <= an_oh ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign d1 = dq[0];
    assign d2 = dq[1];
    assign d3 = dq[2];
    assign d4 = dq[3];
    assign d5 = dq[4];
    assign d6 = dq[5];
    assign d7 = dq[6];
    assign d8 = dq[7];

endmodule
